if_fetch_stage: RTL
===================

# if_fetch_stage

Instruction-fetch stage and IF/ID pipeline register. It sits directly upstream of the opcode decoder, and its `if_id_opcode` output drives the decoder's `opcode` input. It keeps the PC, issues pipelined requests to instruction memory, buffers returned words in a small in-order queue, discards wrong-path words on a branch/jump redirect, and holds the IF/ID register under a decode-stage stall.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 2: maximum of (outstanding requests + queued words). Legal values are 2 and 4.
- `clk` in 1: single clock; every flop updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `im_req_valid` out 1: fetch request valid.
- `im_req_ready` in 1: memory accepts the request; a transfer happens when valid && ready.
- `im_req_addr` out 32: word-aligned fetch address, bits [1:0] always 0.
- `im_rsp_valid` in 1: response word valid. Responses are in order, latency ≥1 cycle, and cannot be back-pressured.
- `im_rsp_data` in 32: instruction word.
- `redirect_valid` in 1: EX-stage taken branch, JAL or JALR.
- `redirect_pc` in 32: new fetch target; bits [1:0] are ignored and forced to 0.
- `id_stall` in 1: hazard hold from decode; freezes the IF/ID register.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `if_id_pc` out 32: PC of the IF/ID instruction.
- `if_id_inst` out 32: instruction word; 32'h0000_0013 (NOP) whenever `if_id_valid`=0.
- `if_id_opcode` out 7: combinational `if_id_inst[6:0]`, wired to the decoder's `opcode` input.

## Operation
- State:
  - `fetch_pc` (32b).
  - PC tag queue, DEPTH entries, pushed on each accepted request.
  - Instruction queue, DEPTH entries of {pc, inst}.
  - `outstanding` counter, 0..DEPTH.
  - `drop_cnt` counter, 0..DEPTH.
  - IF/ID register {valid, pc, inst}.
- Request issue:
  - `im_req_valid` = !redirect_valid && (outstanding + queue_count) < DEPTH.
  - `im_req_addr` = `fetch_pc`.
  - On accept: push `fetch_pc` to the tag queue, then `fetch_pc` += 4 (wraps modulo 2^32) and `outstanding` += 1.
  - While valid && !ready, address and valid stay stable.
- Response:
  - Every response pops the tag queue and decrements `outstanding`.
  - If `drop_cnt` > 0: the word is discarded and `drop_cnt` −= 1.
  - Otherwise {tag, data} goes to the instruction queue. If the queue is empty and IF/ID is loading this cycle, the word bypasses the queue straight into IF/ID.
- IF/ID load: when `id_stall`=0, IF/ID takes the queue head (or the bypass word) with valid=1. If nothing is available, valid=0 and inst=NOP.
- IF/ID hold: when `id_stall`=1, IF/ID is unchanged and the queue keeps filling up to the DEPTH credit limit.
- Redirect, highest priority:
  - `fetch_pc` ← {redirect_pc[31:2], 2'b00}.
  - Instruction queue is cleared.
  - IF/ID valid ← 0 and inst ← NOP, even when `id_stall`=1.
  - `drop_cnt` ← outstanding − (im_rsp_valid ? 1 : 0); a response arriving in the redirect cycle is itself dropped.
  - No request is issued in the redirect cycle.
- Redirect while `drop_cnt` > 0: the new `drop_cnt` is computed from the current `outstanding` as above, replacing the old value (the old in-flight words are already inside `outstanding`).
- Invariants:
  - `drop_cnt` ≤ `outstanding`.
  - `outstanding` + `queue_count` ≤ DEPTH.
  - Tag queue and instruction queue never overflow. An overflow is a design error and must trip an assertion.

## Timing
- Reset values, taken while `rst_n`=0 at a clock edge:
  - `fetch_pc`=RESET_PC.
  - `outstanding`, `drop_cnt` and both queues = 0.
  - `im_req_valid`=0.
  - `if_id_valid`=0, `if_id_pc`=0, `if_id_inst`=32'h13, so `if_id_opcode`=7'h13.
- Reset mid-operation discards all in-flight state. Responses to pre-reset requests must not arrive after reset; the memory is reset on the same `rst_n`.
- First request: `im_req_valid`=1 with addr RESET_PC in the first cycle after `rst_n` rises.
- Latency: with 1-cycle memory, a request accepted in cycle N produces its response in N+1, and the word is visible in IF/ID in N+2.
- Throughput: with DEPTH=2, 1-cycle memory and no stall, one instruction per cycle.
- Redirect penalty: redirect in cycle R; the request to the target is issued in R+1; with 1-cycle memory, the target is in IF/ID in R+3. IF/ID shows NOP in R+1 and R+2.
- Simultaneous stall + redirect: the redirect wins.
- Simultaneous response + pop: the queue count is unchanged.

## Test plan
- Reset and stream:
  - Stimulus: RESET_PC=0x100, 1-cycle memory with ready=1, no stall.
  - Response: requests go to 0x100, 0x104, 0x108… on consecutive cycles. IF/ID shows pc 0x100 two cycles after reset release, then advances by 4 every cycle.
- Stall hold:
  - Stimulus: assert `id_stall` for 3 cycles while pc 0x104 is in IF/ID.
  - Response: IF/ID holds 0x104. At most DEPTH further requests are accepted. After release, 0x108 and 0x10C follow with no gap and no duplicates.
- Redirect drop:
  - Stimulus: 3-cycle memory latency, DEPTH=4, redirect to 0x200 while 3 requests are outstanding.
  - Response: those 3 words are discarded, the next request address is 0x200, and IF/ID shows NOP until the 0x200 word arrives.
- Redirect during stall with a coincident response:
  - Stimulus: assert `id_stall`=1, `redirect_valid`=1 and `im_rsp_valid`=1 in the same cycle.
  - Response: `if_id_valid`=0 next cycle, the response word is never delivered, and `drop_cnt` = outstanding − 1.
- Back-pressure and alignment:
  - Stimulus: `im_req_ready`=0 for 4 cycles, then redirect to 0x3FE.
  - Response: address and valid stay stable while ready=0. The post-redirect address is 0x3FC.
- Wrap-around: RESET_PC=0xFFFF_FFFC gives fetch addresses 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.

Source files
------------

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch with pipelined memory requests, in-order
// response queue, redirect flush/drop and a stallable IF/ID pipeline register.
`default_nettype none

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        im_req_valid,
  input  logic        im_req_ready,
  output logic [31:0] im_req_addr,
  input  logic        im_rsp_valid,
  input  logic [31:0] im_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic [6:0]  if_id_opcode
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   tag_mem [DEPTH];
  logic [AW-1:0] tag_wptr, tag_rptr;
  logic [31:0]   iq_pc   [DEPTH];
  logic [31:0]   iq_inst [DEPTH];
  logic [AW-1:0] iq_wptr, iq_rptr;
  logic [CW-1:0] iq_count, outstanding, drop_cnt;

  logic          req_fire, rsp_keep, iq_empty, load, bypass, iq_push, iq_pop;
  logic [CW:0]   credit_used;
  logic [31:0]   rsp_tag;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign credit_used  = {1'b0, outstanding} + {1'b0, iq_count};
  // Reset gating keeps the request quiet for as long as rst_n is held low.
  assign im_req_valid = rst_n && !redirect_valid && (credit_used < DEPTH_W);
  assign im_req_addr  = fetch_pc;
  assign req_fire     = im_req_valid && im_req_ready;

  assign rsp_tag  = tag_mem[tag_rptr];
  assign rsp_keep = im_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign iq_empty = (iq_count == '0);
  assign load     = !id_stall && !redirect_valid;
  assign bypass   = load && iq_empty && rsp_keep;
  assign iq_pop   = load && !iq_empty;
  assign iq_push  = rsp_keep && !bypass;

  assign if_id_opcode = if_id_inst[6:0];

  // Queue storage carries no reset; occupancy is tracked by pointers and counts.
  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wptr] <= fetch_pc;
    if (iq_push) begin
      iq_pc[iq_wptr]   <= rsp_tag;
      iq_inst[iq_wptr] <= im_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      tag_wptr    <= '0;
      tag_rptr    <= '0;
      iq_wptr     <= '0;
      iq_rptr     <= '0;
      iq_count    <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      if_id_valid <= 1'b0;
      if_id_pc    <= 32'h0;
      if_id_inst  <= NOP;
    end else begin
      if (req_fire)     tag_wptr <= tag_wptr + 1'b1;
      if (im_rsp_valid) tag_rptr <= tag_rptr + 1'b1;
      outstanding <= outstanding + CW'(req_fire) - CW'(im_rsp_valid);

      if (redirect_valid) begin
        fetch_pc    <= {redirect_pc[31:2], 2'b00};
        // Every word still in flight is wrong-path, except one consumed right now.
        drop_cnt    <= outstanding - CW'(im_rsp_valid);
        iq_wptr     <= '0;
        iq_rptr     <= '0;
        iq_count    <= '0;
        if_id_valid <= 1'b0;
        if_id_inst  <= NOP;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (im_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
        if (iq_push) iq_wptr <= iq_wptr + 1'b1;
        if (iq_pop)  iq_rptr <= iq_rptr + 1'b1;
        iq_count <= iq_count + CW'(iq_push) - CW'(iq_pop);
        if (load) begin
          if (!iq_empty) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= iq_pc[iq_rptr];
            if_id_inst  <= iq_inst[iq_rptr];
          end else if (bypass) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= rsp_tag;
            if_id_inst  <= im_rsp_data;
          end else begin
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP;
          end
        end
      end
    end
  end

  a_tag_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(req_fire && outstanding == DEPTH_C));
  a_iq_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(iq_push && iq_count == DEPTH_C));
  a_rsp_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(im_rsp_valid && outstanding == '0));
  a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n)
    drop_cnt <= outstanding);

endmodule

`default_nettype wire
